// File: rtl/load_sched_ctrl.sv
// Purpose : sequences a loadable up counter through a programmable schedule of reload values.
// Latency : LOAD one cycle after start; each entry v takes 2 + TERM - v cycles; done one cycle after last terminal count.
// Backpr. : none; start/cfg_we are simply ignored outside IDLE, abort wins over everything.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   cfg_we/addr/data    schedule write port (accepted in IDLE only)
//   last_idx            final schedule index to run, captured on start
//   start, abort, stop  sequence control (stop only matters with looping)
//   q                   counter value fed back from the counter
//   load, I             counter load strobe and load value
//   busy, done, slot    status: running, one-cycle completion pulse, entry in progress
//
// Build option: define LOAD_SCHED_LOOP_EN to repeat the schedule until stop is seen.
module load_sched_ctrl #(
    parameter int WIDTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [WIDTH-1:0]  cfg_data,
    input  logic [ADDR_W-1:0] last_idx,
    input  logic              start,
    input  logic              abort,
    input  logic              stop,
    input  logic [WIDTH-1:0]  q,
    output logic              load,
    output logic [WIDTH-1:0]  I,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] slot
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [WIDTH-1:0] TERM = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0] last_q;
    logic [WIDTH-1:0]  sched_q [DEPTH];
    logic              stop_eff;

`ifdef LOAD_SCHED_LOOP_EN
    // An early stop pulse is remembered until the sequence returns to IDLE,
    // so the caller need not time it to the end-of-schedule boundary.
    logic stop_seen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_seen_q <= 1'b0;
        end else if (state_d == S_IDLE) begin
            stop_seen_q <= 1'b0;
        end else if (stop && (state_q == S_LOAD || state_q == S_RUN)) begin
            stop_seen_q <= 1'b1;
        end
    end

    assign stop_eff = stop | stop_seen_q;
`else
    // Single-pass build: the end of the schedule always finishes the sequence.
    logic unused_stop;
    assign unused_stop = stop;
    assign stop_eff    = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        if (abort) begin
            // slot is deliberately kept so software can see where it stopped
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        slot_d  = '0;
                    end
                end
                S_LOAD: state_d = S_RUN;
                S_RUN: begin
                    if (q == TERM) begin
                        if (slot_q != last_q) begin
                            slot_d  = slot_q + 1'b1;
                            state_d = S_LOAD;
                        end else if (stop_eff) begin
                            state_d = S_DONE;
                        end else begin
                            slot_d  = '0;
                            state_d = S_LOAD;
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            if (state_q == S_IDLE && start && !abort) begin
                last_q <= last_idx;
            end
        end
    end

    // Schedule is only writable while idle so a running sequence sees stable values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                sched_q[i] <= '0;
            end
        end else if (state_q == S_IDLE && cfg_we) begin
            sched_q[cfg_addr] <= cfg_data;
        end
    end

    // All outputs decode registered state, so reset clears them without a clock edge.
    assign load = (state_q == S_LOAD);
    assign busy = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign slot = slot_q;
    assign I    = sched_q[slot_q];

endmodule

// File: tb/tb_load_sched_ctrl.sv
module tb_load_sched_ctrl;

    localparam int TERM = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic [1:0] last_idx = '0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] q;
    logic       load;
    logic [3:0] I;
    logic       busy;
    logic       done;
    logic [1:0] slot;

    load_sched_ctrl #(.WIDTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .last_idx(last_idx), .start(start), .abort(abort), .stop(stop), .q(q),
        .load(load), .I(I), .busy(busy), .done(done), .slot(slot)
    );

    always #5 clk = ~clk;

    // The counter being sequenced: loads I on load, otherwise counts up and wraps.
    always @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (load) q <= I;
        else q <= q + 4'd1;
    end

    // Reference: the schedule as written, plus an expected output timeline per run.
    typedef struct packed {
        logic       load;
        logic [3:0] i;
        logic [1:0] slot;
        logic       busy;
        logic       done;
    } exp_t;

    logic [3:0] sched_m [4];
    logic [1:0] slot_m;
    exp_t       tl [$];
    int         n_chk = 0;
    int         n_pass = 0;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, "_load"}, load, e.load);
        chk({tag, "_I"},    I,    e.i);
        chk({tag, "_slot"}, slot, e.slot);
        chk({tag, "_busy"}, busy, e.busy);
        chk({tag, "_done"}, done, e.done);
    endtask

    task automatic idle_check(input string tag);
        exp_t e;
        e = '{load: 1'b0, i: sched_m[slot_m], slot: slot_m, busy: 1'b0, done: 1'b0};
        chk_out(tag, e);
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [3:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        step();
        cfg_we = 1'b0;
        sched_m[a] = d;
        idle_check("cfg");
    endtask

    // Each entry v occupies 17 - v cycles (one LOAD, then RUN until q hits 15),
    // followed by one DONE cycle after the final pass.
    task automatic build_timeline(input logic [1:0] L, input int passes, output int pass_len);
        exp_t e;
        tl.delete();
        pass_len = 0;
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k <= int'(L); k++) begin
                int n;
                n = 2 + TERM - int'(sched_m[k]);
                for (int j = 0; j < n; j++) begin
                    e = '{load: (j == 0), i: sched_m[k], slot: 2'(k), busy: 1'b1, done: 1'b0};
                    tl.push_back(e);
                end
                if (p == 0) pass_len += n;
            end
        end
        e = '{load: 1'b0, i: sched_m[L], slot: L, busy: 1'b0, done: 1'b1};
        tl.push_back(e);
    endtask

    task automatic run_seq(input logic [1:0] L, input int passes, input int abort_at, input bit mischief);
        int pass_len;
        int stop_at;
        build_timeline(L, passes, pass_len);
        stop_at = (passes - 1) * pass_len + 1;
        start = 1'b1;
        last_idx = L;
        for (int c = 0; c < tl.size(); c++) begin
            step();
            start = 1'b0; cfg_we = 1'b0; stop = 1'b0; abort = 1'b0;
            if (c == 0) last_idx = 2'($urandom);
            chk_out($sformatf("seq_c%0d", c), tl[c]);
            if (c == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                slot_m = tl[c].slot;
                idle_check("abort");
                step();
                idle_check("abort_hold");
                return;
            end
            if (c == stop_at) stop = 1'b1;
            if (mischief) begin
                if ($urandom_range(0, 3) == 0) start = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    cfg_we = 1'b1;
                    cfg_addr = 2'($urandom);
                    cfg_data = 4'($urandom);
                end
`ifndef LOAD_SCHED_LOOP_EN
                if ($urandom_range(0, 3) == 0) stop = 1'b1;
`endif
            end
        end
        step();
        start = 1'b0; cfg_we = 1'b0; stop = 1'b0;
        slot_m = L;
        idle_check("post");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) sched_m[i] = '0;
        slot_m = '0;

        // reset values while held in reset
        #1;
        chk("rst_load", load, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_slot", slot, 0);
        chk("rst_I", I, 0);
        #10 rst = 1'b1;
        step();
        idle_check("rst_idle");

        // basic two-entry run
        write_cfg(2'd0, 4'hC);
        write_cfg(2'd1, 4'hE);
        write_cfg(2'd2, 4'h3);
        write_cfg(2'd3, 4'hF);
        run_seq(2'd1, 1, -1, 1'b0);

        // terminal-count entry: LOAD, one RUN cycle, DONE
        write_cfg(2'd0, 4'hF);
        run_seq(2'd0, 1, -1, 1'b0);

        // abort on the first RUN cycle of slot 1
        write_cfg(2'd0, 4'hC);
        run_seq(2'd1, 1, (2 + TERM - 12) + 1, 1'b0);

        // start together with abort in IDLE stays idle
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        idle_check("start_abort");

        // writes and restarts while busy must not disturb the run
        run_seq(2'd3, 1, -1, 1'b1);
        run_seq(2'd0, 1, -1, 1'b0);

        // asynchronous reset mid-RUN
        start = 1'b1; last_idx = 2'd3;
        step();
        start = 1'b0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_load", load, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_slot", slot, 0);
        chk("mid_rst_I", I, 0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) sched_m[i] = '0;
        slot_m = '0;
        step();
        idle_check("after_rst");
        run_seq(2'd0, 1, -1, 1'b0);

        // randomized runs
        for (int r = 0; r < 12; r++) begin
            int ab;
            for (int k = 0; k < 4; k++) write_cfg(2'(k), 4'($urandom_range(6, 15)));
            build_timeline(2'($urandom), 1, ab);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
            run_seq(2'($urandom), 1, ab, 1'b1);
        end

`ifdef LOAD_SCHED_LOOP_EN
        // looping: three passes over slots 0,1, stop pulsed in slot 0 of the last
        write_cfg(2'd0, 4'hD);
        write_cfg(2'd1, 4'hE);
        run_seq(2'd1, 3, -1, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
